// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction memory request/response bus
interface instruction_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner, imem fetch handshake and next-PC selection
// Optional IFU_PERF_CNT_EN adds instret_cnt/stall_cnt counters.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          IMEM_TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   instruction_fetch_unit_if.master mem,
   output logic [31:0]             ins,
   output logic                    ins_valid,
   input  logic                    ins_ack,
   output logic [31:0]             pc,
   output logic [31:0]             pc_plus4,
   input  logic                    BR,
   input  logic                    PCToReg,
   input  logic                    aluToPC,
   input  logic                    br_taken,
   input  logic [31:0]             imm,
   input  logic [31:0]             alu_result,
   output logic                    fetch_err,
   output logic [1:0]              err_cause
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]             instret_cnt,
   output logic [31:0]             stall_cnt
`endif
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;

   localparam logic [31:0] TMO_LAST = 32'(IMEM_TIMEOUT - 1);

   state_t      state;
   logic [31:0] tmo_cnt;
   logic [31:0] target;

   assign pc_plus4      = pc + 32'd4;
   assign mem.imem_addr = pc;

   always_comb begin
      target = pc_plus4;
      if (aluToPC)
         target = {alu_result[31:1], 1'b0};
      else if (BR && (PCToReg || br_taken))
         target = pc + imm;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         ins          <= 32'd0;
         ins_valid    <= 1'b0;
         mem.imem_req <= 1'b0;
         fetch_err    <= 1'b0;
         err_cause    <= 2'b00;
         tmo_cnt      <= 32'd0;
`ifdef IFU_PERF_CNT_EN
         instret_cnt  <= 32'd0;
         stall_cnt    <= 32'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               state        <= REQ;
               mem.imem_req <= 1'b1;
            end
            REQ: begin
               if (mem.imem_ready) begin
                  state        <= WAIT;
                  mem.imem_req <= 1'b0;
                  tmo_cnt      <= 32'd0;
               end
`ifdef IFU_PERF_CNT_EN
               else
                  stall_cnt <= stall_cnt + 32'd1;
`endif
            end
            WAIT: begin
               if (mem.imem_rvalid) begin
                  ins       <= mem.imem_rdata;
                  ins_valid <= 1'b1;
                  state     <= HOLD;
               end else begin
`ifdef IFU_PERF_CNT_EN
                  stall_cnt <= stall_cnt + 32'd1;
`endif
                  // tmo_cnt counts WAIT cycles already spent; this is cycle tmo_cnt+1
                  if (IMEM_TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
                     state     <= FAULT;
                     fetch_err <= 1'b1;
                     err_cause <= 2'b10;
                  end else begin
                     tmo_cnt <= tmo_cnt + 32'd1;
                  end
               end
            end
            HOLD: begin
               if (ins_ack) begin
                  ins_valid <= 1'b0;
                  if (target[1:0] != 2'b00) begin
                     state     <= FAULT;
                     fetch_err <= 1'b1;
                     err_cause <= 2'b01;
                  end else begin
                     pc           <= target;
                     state        <= REQ;
                     mem.imem_req <= 1'b1;
`ifdef IFU_PERF_CNT_EN
                     instret_cnt  <= instret_cnt + 32'd1;
`endif
                  end
               end
            end
            FAULT: begin
               state        <= FAULT;
               ins_valid    <= 1'b0;
               mem.imem_req <= 1'b0;
               fetch_err    <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed vector bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, rst2 = 1'b1;
   logic        ins_ack = 1'b0, ack2 = 1'b0;
   logic        BR = 1'b0, PCToReg = 1'b0, aluToPC = 1'b0, br_taken = 1'b0;
   logic [31:0] imm = 32'd0, alu_result = 32'd0;

   logic [31:0] ins, pc, pc_plus4;
   logic        ins_valid, fetch_err;
   logic [1:0]  err_cause;
   logic [31:0] t_ins, t_pc, t_pc4;
   logic        t_ins_valid, t_fetch_err;
   logic [1:0]  t_err_cause;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] instret_cnt, stall_cnt, t_instret, t_stall;
`endif

   instruction_fetch_unit_if m1();
   instruction_fetch_unit_if m2();

   instruction_fetch_unit #(.RESET_PC(32'h100)) dut (
      .clk(clk), .rst(rst), .mem(m1),
      .ins(ins), .ins_valid(ins_valid), .ins_ack(ins_ack),
      .pc(pc), .pc_plus4(pc_plus4),
      .BR(BR), .PCToReg(PCToReg), .aluToPC(aluToPC), .br_taken(br_taken),
      .imm(imm), .alu_result(alu_result),
`ifdef IFU_PERF_CNT_EN
      .instret_cnt(instret_cnt), .stall_cnt(stall_cnt),
`endif
      .fetch_err(fetch_err), .err_cause(err_cause)
   );

   instruction_fetch_unit #(.RESET_PC(32'h100), .IMEM_TIMEOUT(5)) dut_tmo (
      .clk(clk), .rst(rst2), .mem(m2),
      .ins(t_ins), .ins_valid(t_ins_valid), .ins_ack(ack2),
      .pc(t_pc), .pc_plus4(t_pc4),
      .BR(BR), .PCToReg(PCToReg), .aluToPC(aluToPC), .br_taken(br_taken),
      .imm(imm), .alu_result(alu_result),
`ifdef IFU_PERF_CNT_EN
      .instret_cnt(t_instret), .stall_cnt(t_stall),
`endif
      .fetch_err(t_fetch_err), .err_cause(t_err_cause)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Wait for a request, stall it rdly cycles, then return word vdly cycles after the handshake.
   task automatic serve(input logic [31:0] addr, input int rdly, input int vdly, input logic [31:0] word);
      int n = 0;
      logic [31:0] bad = 0;
      while (m1.imem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_seen", {31'd0, m1.imem_req}, 32'd1);
      check("imem_addr", m1.imem_addr, addr);
      for (int i = 0; i < rdly; i++) begin
         m1.imem_ready = 1'b0;
         m1.imem_rvalid = 1'b1;
         m1.imem_rdata = 32'hDEAD_BEEF;
         @(negedge clk);
         if (m1.imem_req !== 1'b1 || m1.imem_addr !== addr) bad = 1;
      end
      m1.imem_rvalid = 1'b0;
      m1.imem_ready = 1'b1;
      @(negedge clk);
      m1.imem_ready = 1'b0;
      for (int i = 0; i < vdly; i++) begin
         @(negedge clk);
         if (m1.imem_req !== 1'b0 || ins_valid !== 1'b0) bad = 1;
      end
      check("req_stable", bad, 32'd0);
      m1.imem_rvalid = 1'b1;
      m1.imem_rdata = word;
      @(negedge clk);
      m1.imem_rvalid = 1'b0;
      check("ins_valid_hold", {31'd0, ins_valid}, 32'd1);
      check("ins_word", ins, word);
      check("pc_hold", pc, addr);
   endtask

   task automatic do_ack(input logic b, input logic p, input logic a, input logic t,
                         input logic [31:0] im, input logic [31:0] al);
      BR = b; PCToReg = p; aluToPC = a; br_taken = t; imm = im; alu_result = al;
      ins_ack = 1'b1;
      @(negedge clk);
      ins_ack = 1'b0;
      BR = 1'b0; PCToReg = 1'b0; aluToPC = 1'b0; br_taken = 1'b0;
      imm = 32'h5555_5555; alu_result = 32'hAAAA_AAAA;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      check("rst_pc", pc, 32'h100);
      check("rst_req", {31'd0, m1.imem_req}, 32'd0);
      check("rst_valid", {31'd0, ins_valid}, 32'd0);
      check("rst_ins", ins, 32'd0);
      check("rst_err", {29'd0, fetch_err, err_cause}, 32'd0);
      rst = 1'b0;
   endtask

   typedef struct {
      logic [31:0] start;
      logic        b, p, a, t;
      logic [31:0] im, al, exp;
      int          rdly, vdly;
   } vec_t;
   vec_t vecs[8];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] bad;
      m1.imem_ready = 0; m1.imem_rvalid = 0; m1.imem_rdata = 0;
      m2.imem_ready = 0; m2.imem_rvalid = 0; m2.imem_rdata = 0;

      vecs[0] = '{32'h200, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0,    32'h1F0,  0, 0};
      vecs[1] = '{32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0,    32'h204,  1, 0};
      vecs[2] = '{32'h300, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h1235, 32'h1234, 0, 1};
      vecs[3] = '{32'h300, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40,       32'h0,    32'h340,  2, 2};
      vecs[4] = '{32'h300, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100,      32'h500,  32'h500,  0, 0};
      vecs[5] = '{32'h300, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100,      32'h0,    32'h304,  0, 0};
      vecs[6] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,    32'h0,    0, 0};
      vecs[7] = '{32'h800, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FF00, 32'h0,   32'h700,  0, 0};

      @(negedge clk);
      do_reset();

      // Sequential fetch with zero-wait memory
      serve(32'h100, 0, 0, 32'h0000_0013);
      check("pc_plus4", pc_plus4, 32'h104);
      do_ack(0, 0, 0, 0, 0, 0);
      check("valid_drop", {31'd0, ins_valid}, 32'd0);
      serve(32'h104, 0, 0, 32'h0010_0093);
      do_ack(0, 0, 0, 0, 0, 0);
      serve(32'h108, 0, 0, 32'h0020_0113);

      for (int k = 0; k < 8; k++) begin
         do_ack(0, 0, 1, 0, 0, vecs[k].start);
         serve(vecs[k].start, 0, 0, vecs[k].start ^ 32'h1357_0000);
         do_ack(vecs[k].b, vecs[k].p, vecs[k].a, vecs[k].t, vecs[k].im, vecs[k].al);
         check($sformatf("vec%0d_next_req", k), {31'd0, m1.imem_req}, 32'd1);
         serve(vecs[k].exp, vecs[k].rdly, vecs[k].vdly, vecs[k].exp ^ 32'h2468_0000);
      end

      // Misaligned JAL target faults and stays put
      do_ack(0, 0, 1, 0, 0, 32'h400);
      serve(32'h400, 0, 0, 32'h0060_006F);
      do_ack(1, 1, 0, 0, 32'h6, 0);
      check("fault_err", {31'd0, fetch_err}, 32'd1);
      check("fault_cause", {30'd0, err_cause}, 32'd1);
      check("fault_valid", {31'd0, ins_valid}, 32'd0);
      check("fault_pc", pc, 32'h400);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         m1.imem_ready = 1'b1;
         m1.imem_rvalid = 1'b1;
         @(negedge clk);
         if (m1.imem_req !== 1'b0 || fetch_err !== 1'b1 || ins_valid !== 1'b0) bad = 1;
      end
      m1.imem_ready = 1'b0;
      m1.imem_rvalid = 1'b0;
      check("fault_sticky", bad, 32'd0);
      do_reset();

      // Odd JALR result gets bit 0 cleared but bit 1 still misaligns
      serve(32'h100, 0, 0, 32'h0000_0067);
      do_ack(0, 0, 1, 0, 0, 32'h1237);
      check("jalr_mis_cause", {30'd0, err_cause}, 32'd1);
      check("jalr_mis_pc", pc, 32'h100);
      do_reset();

      // Reset during WAIT, then a late rvalid must be ignored
      serve(32'h100, 0, 0, 32'h1111_1111);
      do_ack(0, 0, 0, 0, 0, 0);
      check("wait_req", {31'd0, m1.imem_req}, 32'd1);
      m1.imem_ready = 1'b1;
      @(negedge clk);
      m1.imem_ready = 1'b0;
      do_reset();
      m1.imem_rvalid = 1'b1;
      m1.imem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      m1.imem_rvalid = 1'b0;
      check("late_rvalid_valid", {31'd0, ins_valid}, 32'd0);
      check("late_rvalid_ins", ins, 32'd0);
      // Reset during HOLD
      serve(32'h100, 0, 0, 32'h2222_2222);
      do_reset();

      // Back-pressure: 3 ready-low cycles then 4 wait cycles = 7 stalls, 3 retired
      serve(32'h100, 3, 4, 32'hCAFE_F00D);
      do_ack(0, 0, 0, 0, 0, 0);
      serve(32'h104, 0, 0, 32'h3333_3333);
      do_ack(0, 0, 0, 0, 0, 0);
      serve(32'h108, 0, 0, 32'h4444_4444);
      do_ack(0, 0, 0, 0, 0, 0);
`ifdef IFU_PERF_CNT_EN
      check("instret_cnt", instret_cnt, 32'd3);
      check("stall_cnt", stall_cnt, 32'd7);
`endif

      // Timeout instance: ready handshake, then no rvalid
      rst2 = 1'b0;
      for (int n = 0; n < 20 && m2.imem_req !== 1'b1; n++) @(negedge clk);
      check("tmo_req", {31'd0, m2.imem_req}, 32'd1);
      m2.imem_ready = 1'b1;
      @(negedge clk);
      m2.imem_ready = 1'b0;
      repeat (4) @(negedge clk);
      check("tmo_not_yet", {31'd0, t_fetch_err}, 32'd0);
      @(negedge clk);
      check("tmo_err", {31'd0, t_fetch_err}, 32'd1);
      check("tmo_cause", {30'd0, t_err_cause}, 32'd2);
      check("tmo_req_low", {31'd0, m2.imem_req}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the control unit and immediate generator.
- Owns the program counter and runs a request/response handshake with instruction memory.
- Presents one fetched instruction at a time to decode, with a valid/ack handshake.
- Computes the next PC (sequential, branch, JAL, JALR) from the resolved control and datapath results returned by execute when decode acknowledges the instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- IMEM_TIMEOUT, 255, cycles waited in WAIT before raising fetch_err; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch byte address; equals pc while imem_req=1.
- imem_ready  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  instruction data valid.
- imem_rdata  input  32  instruction word.
- ins  output  32  held instruction to decode.
- ins_valid  output  1  ins is valid.
- ins_ack  input  1  decode/execute has retired ins; next-PC inputs are valid this cycle.
- pc  output  32  address of ins.
- pc_plus4  output  32  pc+4, for the JAL/JALR link write.
- BR  input  1  control-flow instruction.
- PCToReg  input  1  unconditional jump (JAL/JALR).
- aluToPC  input  1  JALR; target comes from the ALU.
- br_taken  input  1  branch comparison true (ALU zero/compare).
- imm  input  32  sign-extended immediate from the immediate generator.
- alu_result  input  32  ALU output (rs1+imm for JALR).
- fetch_err  output  1  sticky fault flag.
- err_cause  output  2  01 = misaligned target, 10 = memory timeout, 00 = none.

Behaviour:
- States: IDLE, REQ, WAIT, HOLD, FAULT.
- Reset, from any state at any point: state=IDLE, pc=RESET_PC, ins=0, ins_valid=0, imem_req=0, fetch_err=0, err_cause=00, timeout counter=0.
  - Any response still in flight is discarded; the memory shares rst.
- IDLE: one cycle, then REQ.
- REQ: imem_req=1, imem_addr=pc, held stable until imem_ready=1.
  - On the ready cycle, go to WAIT and clear the timeout counter.
  - imem_rvalid in REQ is ignored.
- WAIT: imem_req=0.
  - On imem_rvalid=1: ins<=imem_rdata, ins_valid<=1, go to HOLD. Earliest ins_valid is 2 cycles after the ready handshake cycle.
  - Timeout: if the counter reaches IMEM_TIMEOUT (and IMEM_TIMEOUT≠0), go to FAULT with err_cause=10.
- HOLD: ins_valid=1; ins and pc stable until ins_ack=1.
  - On ins_ack, target is chosen in priority order:
    1. aluToPC=1: target = {alu_result[31:1],1'b0}.
    2. BR=1 & (PCToReg=1 | br_taken=1): target = pc+imm.
    3. Otherwise: target = pc+4.
  - All additions are modulo 2^32; wrap-around from 32'hFFFF_FFFC+4 gives 0 with no error.
  - If target[1:0]≠00: go to FAULT with err_cause=01; pc keeps the faulting instruction's address.
  - Otherwise: pc<=target, ins_valid<=0, go to REQ (next cycle).
  - Control inputs are sampled only in the ack cycle of HOLD; they are ignored in every other state.
- FAULT: ins_valid=0, imem_req=0, fetch_err=1; left only by rst.
- pc_plus4 is combinational: pc+4.
- Steady-state throughput with zero-wait memory (ready in the REQ cycle, rvalid the next cycle, ack in the first HOLD cycle): one instruction per 3 cycles.

Optional Feature:
- Macro IFU_PERF_CNT_EN.
- When defined, adds two output ports:
  - instret_cnt [31:0]: +1 on every accepted ins_ack that does not fault.
  - stall_cnt [31:0]: +1 on every cycle spent in REQ with imem_ready=0 or in WAIT with imem_rvalid=0.
- Both counters reset to 0, wrap at 2^32, and freeze in FAULT.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=32'h100, zero-wait memory, ack on every instruction, no BR -> imem_addr sequence 0x100, 0x104, 0x108; ins_valid asserted in HOLD only; pc_plus4=0x104 while pc=0x100.
- Branch taken at pc=0x200, BR=1, br_taken=1, imm=32'hFFFF_FFF0 -> next imem_addr=0x1F0. Same with br_taken=0 -> 0x204.
- JALR at pc=0x300, aluToPC=1, alu_result=0x1235 -> next imem_addr=0x1234. JAL with PCToReg=1, BR=1, br_taken=0, imm=0x40 -> 0x340.
- Misaligned JAL target imm=0x6 at pc=0x400 -> FAULT; fetch_err=1, err_cause=01, imem_req stays 0 for 10 cycles; rst returns pc to RESET_PC.
- Memory back-pressure: imem_ready low 3 cycles, then rvalid after 4 more -> imem_addr stable throughout; ins equals the returned word. With IMEM_TIMEOUT=5 and no rvalid -> err_cause=10 after 5 WAIT cycles.
- rst asserted in WAIT and again in HOLD -> next cycle all outputs at reset values; a late rvalid is ignored. With IFU_PERF_CNT_EN, after 3 acks and 7 stall cycles -> instret_cnt=3, stall_cnt=7.
